// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with registered occupancy count
// Optional empty-FIFO bypass enabled by defining SYNC_FIFO_BYPASS_EN.
module sync_fifo #(
  parameter int ELEM_WIDTH = 8,
  parameter int FIFO_SIZE  = 2
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic [ELEM_WIDTH-1:0] elem_in_i,
  input  logic                  elem_in_valid_i,
  output logic                  elem_in_ready_o,
  output logic [ELEM_WIDTH-1:0] elem_out_o,
  output logic                  elem_out_valid_o,
  input  logic                  elem_out_ready_i,
  output logic [FIFO_SIZE:0]    count_o
);

  localparam int DEPTH = 2 ** FIFO_SIZE;
  localparam logic [FIFO_SIZE:0] PTR_ONE = {{FIFO_SIZE{1'b0}}, 1'b1};

  logic [ELEM_WIDTH-1:0] storage [DEPTH];
  logic [FIFO_SIZE:0]    wr_ptr;
  logic [FIFO_SIZE:0]    rd_ptr;
  logic [FIFO_SIZE:0]    count;
  logic                  full;
  logic                  empty;
  logic                  hsi;
  logic                  hso;
  logic                  wr_en;
  logic                  rd_en;

  assign full  = (wr_ptr[FIFO_SIZE] != rd_ptr[FIFO_SIZE]) &&
                 (wr_ptr[FIFO_SIZE-1:0] == rd_ptr[FIFO_SIZE-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign elem_in_ready_o = !full && !srst_i;
  assign hsi = elem_in_valid_i && elem_in_ready_o;
  assign hso = elem_out_valid_o && elem_out_ready_i;

`ifdef SYNC_FIFO_BYPASS_EN
  // An element consumed straight through an empty FIFO never touches storage.
  assign elem_out_valid_o = empty ? (elem_in_valid_i && !srst_i) : 1'b1;
  assign elem_out_o       = empty ? elem_in_i : storage[rd_ptr[FIFO_SIZE-1:0]];
  assign wr_en            = hsi && !(empty && hso);
`else
  assign elem_out_valid_o = !empty;
  assign elem_out_o       = storage[rd_ptr[FIFO_SIZE-1:0]];
  assign wr_en            = hsi;
`endif

  assign rd_en   = hso && !empty && !srst_i;
  assign count_o = count;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count <= count + PTR_ONE;
        2'b01:   count <= count - PTR_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) storage[wr_ptr[FIFO_SIZE-1:0]] <= elem_in_i;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard testbench for sync_fifo (ELEM_WIDTH=8, FIFO_SIZE=2)
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       srst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  sync_fifo #(.ELEM_WIDTH(8), .FIFO_SIZE(2)) dut (
    .clk_i           (clk),
    .srst_i          (srst),
    .elem_in_i       (in_data),
    .elem_in_valid_i (in_valid),
    .elem_in_ready_o (in_ready),
    .elem_out_o      (out_data),
    .elem_out_valid_o(out_valid),
    .elem_out_ready_i(out_ready),
    .count_o         (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    step(); step();
    srst = 1'b0;
    settle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", in_ready); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    sb.delete();
  endtask

  task automatic test_fill();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      settle();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got %0b want 1", i, in_ready); end
      if (in_ready) sb.push_back(vals[i]);
      step();
      checks++; if (int'(count) !== i + 1) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
    end
    in_valid = 1'b1; in_data = 8'h55;
    settle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL overflow_count got %0d want 4", count); end
  endtask

  task automatic test_drain();
    logic [7:0] exp;
    out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++; $display("FAIL drain[%0d] got v=%0b d=%02h want v=1 d=%02h", i, out_valid, out_data, exp);
      end
      step();
    end
    settle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %0b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d want 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
      settle(); sb.push_back(in_data);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'hB0 + 8'(i);
      settle();
      exp = sb.pop_front();
      sb.push_back(in_data);
      checks++; if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_data[%0d] got v=%0b d=%02h r=%0b want v=1 d=%02h r=1", i, out_valid, out_data, in_ready, exp);
      end
      step();
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count[%0d] got %0d want 2", i, count); end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      exp = sb.pop_front();
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++; $display("FAIL b2b_tail[%0d] got v=%0b d=%02h want v=1 d=%02h", i, out_valid, out_data, exp);
      end
      step();
    end
    out_ready = 1'b0;
    settle();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_end_count got %0d want 0", count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'hC0 + 8'(i);
      step();
    end
    in_valid = 1'b1; in_data = 8'hCF; srst = 1'b1;
    settle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready_during got %0b want 0", in_ready); end
    step();
    srst = 1'b0; in_valid = 1'b0;
    settle();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0) begin
      errors++; $display("FAIL rst_mid_state got v=%0b r=%0b c=%0d want v=0 r=1 c=0", out_valid, in_ready, count);
    end
    in_valid = 1'b1; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    settle();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h77 || count !== 3'd1) begin
      errors++; $display("FAIL rst_mid_fresh got v=%0b d=%02h c=%0d want v=1 d=77 c=1", out_valid, out_data, count);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    settle();
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL rst_mid_drain got v=%0b c=%0d want v=0 c=0", out_valid, count);
    end
    sb.delete();
  endtask

  task automatic test_latency();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    settle();
`ifdef SYNC_FIFO_BYPASS_EN
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      errors++; $display("FAIL lat_same got v=%0b d=%02h want v=1 d=a5", out_valid, out_data);
    end
    step();
    in_valid = 1'b0;
    settle();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL lat_after got c=%0d v=%0b want c=0 v=0", count, out_valid);
    end
`else
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_same got v=%0b want 0", out_valid); end
    step();
    in_valid = 1'b0;
    settle();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || count !== 3'd1) begin
      errors++; $display("FAIL lat_next got v=%0b d=%02h c=%0d want v=1 d=a5 c=1", out_valid, out_data, count);
    end
    step();
    settle();
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL lat_consumed got v=%0b c=%0d want v=0 c=0", out_valid, count);
    end
`endif
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] exp;
    int fails = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      settle();
      if (fails < 10) begin
        checks++; if (int'(count) !== sb.size() || count > 3'd4) begin
          errors++; fails++; $display("FAIL rand_count[%0d] got %0d want %0d", cyc, count, sb.size());
        end
        checks++; if (in_ready !== (sb.size() < 4)) begin
          errors++; fails++; $display("FAIL rand_ready[%0d] got %0b want %0b", cyc, in_ready, sb.size() < 4);
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      if (out_valid && out_ready) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        if (fails < 10) begin
          checks++; if (out_data !== exp) begin
            errors++; fails++; $display("FAIL rand_data[%0d] got %02h want %02h", cyc, out_data, exp);
          end
        end
      end
`ifndef SYNC_FIFO_BYPASS_EN
      if (fails < 10) begin
        checks++; if (out_valid !== (int'(count) != 0)) begin
          errors++; fails++; $display("FAIL rand_valid[%0d] got %0b", cyc, out_valid);
        end
      end
`endif
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_reset_mid();
    test_latency();
    test_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter ELEM_WIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter FIFO_SIZE, default 2, log2 of depth (depth = 2**FIFO_SIZE, FIFO_SIZE >= 1).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port srst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port elem_in_i  input  ELEM_WIDTH  input element.
REQ-006 SHALL have port elem_in_valid_i  input  1  input valid.
REQ-007 SHALL have port elem_in_ready_o  output  1  input ready.
REQ-008 SHALL have port elem_out_o  output  ELEM_WIDTH  output element (head of queue).
REQ-009 SHALL have port elem_out_valid_o  output  1  output valid.
REQ-010 SHALL have port elem_out_ready_i  input  1  output ready.
REQ-011 SHALL have port count_o  output  FIFO_SIZE+1  current occupancy, 0..2**FIFO_SIZE.

Function
REQ-012 SHALL define input handshake hsi = elem_in_valid_i & elem_in_ready_o; output handshake hso = elem_out_valid_o & elem_out_ready_i.
REQ-013 SHALL keep binary wr/rd pointers of FIFO_SIZE+1 bits; low FIFO_SIZE bits address storage, MSB is wrap bit; increment modulo 2**(FIFO_SIZE+1).
REQ-014 SHALL flag full when pointer MSBs differ and low bits are equal; empty when pointers are equal.
REQ-015 SHALL drive elem_in_ready_o = !full & !srst_i; ready SHALL NOT depend on elem_out_ready_i (no same-cycle pass-through when full).
REQ-016 SHALL drive elem_out_valid_o = !empty (except REQ-029); elem_out_o = storage[rd_ptr low bits], combinational (first-word-fall-through).
REQ-017 SHALL, on hsi, write elem_in_i to storage[wr_ptr] and increment wr_ptr at the same edge.
REQ-018 SHALL, on hso, increment rd_ptr at the same edge.
REQ-019 SHALL give a pushed element a latency of 1 cycle: valid on output the cycle after its hsi when the FIFO was empty.
REQ-020 SHALL, on simultaneous hsi and hso, leave count_o unchanged and advance both pointers.
REQ-021 SHALL update count_o as a register: +1 on hsi only, -1 on hso only, unchanged otherwise; count_o SHALL equal wr_ptr - rd_ptr at all times.
REQ-022 SHALL hold elem_out_o stable while elem_out_valid_o=1 and elem_out_ready_i=0.
REQ-023 SHALL preserve order and data across pointer wrap-around with no loss or duplication.

Reset
REQ-024 SHALL, on a rising edge with srst_i=1, clear wr_ptr, rd_ptr and count_o to 0; storage contents are not cleared.
REQ-025 SHALL, after reset, present elem_out_valid_o=0, elem_in_ready_o=1, count_o=0.
REQ-026 SHALL ignore hsi/hso while srst_i=1 and discard all held elements when reset is asserted mid-operation.

Configuration
REQ-027 SHALL support macro SYNC_FIFO_BYPASS_EN, controlling empty-FIFO bypass.
REQ-028 SHALL, without SYNC_FIFO_BYPASS_EN, behave per REQ-016/REQ-019 (minimum latency 1 cycle).
REQ-029 SHALL, with SYNC_FIFO_BYPASS_EN and the FIFO empty, drive elem_out_valid_o = elem_in_valid_i & !srst_i and elem_out_o = elem_in_i combinationally; if hso occurs in that cycle the element is consumed and SHALL NOT be written (pointers and count unchanged); if no hso, it is written per REQ-017.

Verification
REQ-030 SHALL cover fill: ELEM_WIDTH=8, FIFO_SIZE=2, out_ready=0, push 0x11,0x22,0x33,0x44 -> count_o 1,2,3,4; in_ready=0 after 4th; 5th push 0x55 is not accepted.
REQ-031 SHALL cover drain: from full, out_ready=1 -> outputs 0x11,0x22,0x33,0x44 in consecutive cycles, then valid=0, count_o=0.
REQ-032 SHALL cover simultaneous push/pop at count 2 for 10 cycles -> count_o stays 2, order intact across pointer wrap.
REQ-033 SHALL cover reset mid-operation: count 3, assert srst_i one cycle -> next cycle valid=0, ready=1, count_o=0; old data never emitted.
REQ-034 SHALL cover latency: empty, push 0xA5 with out_ready=1 -> without macro valid=1 with 0xA5 next cycle; with SYNC_FIFO_BYPASS_EN valid=1 with 0xA5 same cycle, count_o stays 0.
REQ-035 SHALL cover random valid/ready traffic for 10000 cycles against a reference queue -> no mismatch, count_o never exceeds 4.
